// File: rtl/data_mem_ctrl_if.sv
// Single-port data memory bus between the load/store controller (master) and the memory (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Memory-stage load/store controller: lane formatting, req/ack bus transaction with watchdog, load return.
// Optional build macro MISALIGN_TRAP_EN adds misalign_err and traps misaligned H/W accesses instead of aligning them.
module data_mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  data_mem_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_ZERO = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  // Select the addressed lane and extend; funct3 011/110/111 fall through to a full word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h000000, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0000, h};
      default: fmt_load = word;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          lane_q, lane_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                mem_ready_q, mem_ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                bus_err_q, bus_err_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [3:0]          st_be_s;
  logic [31:0]         st_wdata_s;
  logic                unused_addr_s;
`ifdef MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
  logic                misalign_err_q, misalign_err_d;
  logic                mis_s;
`endif

  assign unused_addr_s = ^addr[31:ADDR_W+2];

  // Store lane steering; misaligned H/W simply drop the low address bits.
  always_comb begin
    st_be_s    = 4'b1111;
    st_wdata_s = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be_s    = 4'b0001 << addr[1:0];
        st_wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_s    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_s = {2{wdata[15:0]}};
      end
      default: begin
        st_be_s    = 4'b1111;
        st_wdata_s = wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Halfword needs addr[0]=0; any word-sized access needs addr[1:0]=0.
  always_comb begin
    mis_s = ((funct3[1:0] == 2'b01) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
  end
`endif

  // Next-state and next-output computation for the IDLE/BUSY/RESP controller.
  always_comb begin
    state_d       = state_q;
    is_load_d     = is_load_q;
    funct3_d      = funct3_q;
    lane_d        = lane_q;
    wd_d          = wd_q;
    mem_ready_d   = mem_ready_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d     = misalign_q;
    misalign_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        mem_ready_d = 1'b1;
        if (req_valid && (mem_read || mem_write)) begin
          state_d     = ST_BUSY;
          is_load_d   = mem_read;
          funct3_d    = funct3;
          lane_d      = addr[1:0];
          wd_d        = WD_ZERO;
          mem_ready_d = 1'b0;
          bus_we_d    = ~mem_read;
          bus_addr_d  = addr[ADDR_W+1:2];
          bus_be_d    = mem_read ? 4'b1111 : st_be_s;
          bus_wdata_d = mem_read ? 32'h0000_0000 : st_wdata_s;
`ifdef MISALIGN_TRAP_EN
          misalign_d  = mis_s;
          bus_req_d   = ~mis_s;
`else
          bus_req_d   = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef MISALIGN_TRAP_EN
        if (misalign_q) begin
          state_d        = ST_RESP;
          mem_ready_d    = 1'b1;
          bus_req_d      = 1'b0;
          rdata_d        = 32'h0000_0000;
          rdata_valid_d  = is_load_q;
          misalign_err_d = 1'b1;
        end else
`endif
        if (bus.bus_ack) begin
          state_d       = ST_RESP;
          mem_ready_d   = 1'b1;
          bus_req_d     = 1'b0;
          rdata_valid_d = is_load_q;
          rdata_d       = is_load_q ? fmt_load(funct3_q, lane_q, bus.bus_rdata) : rdata_q;
        end else if (wd_q == WD_LAST) begin
          // Watchdog expiry abandons the transaction and clears the load result.
          state_d       = ST_RESP;
          wd_d          = wd_q + WD_ONE;
          mem_ready_d   = 1'b1;
          bus_req_d     = 1'b0;
          rdata_d       = 32'h0000_0000;
          rdata_valid_d = is_load_q;
          bus_err_d     = 1'b1;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        mem_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_ready_d = 1'b1;
        bus_req_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_IDLE;
      is_load_q     <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wd_q          <= WD_ZERO;
      mem_ready_q   <= 1'b1;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= {ADDR_W{1'b0}};
      bus_be_q      <= 4'b0000;
      bus_wdata_q   <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
      misalign_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      is_load_q     <= is_load_d;
      funct3_q      <= funct3_d;
      lane_q        <= lane_d;
      wd_q          <= wd_d;
      mem_ready_q   <= mem_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q     <= misalign_d;
      misalign_err_q <= misalign_err_d;
`endif
    end
  end

  assign mem_ready     = mem_ready_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign bus_err       = bus_err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err  = misalign_err_q;
`endif

endmodule
